alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Multicycle command front-end that drives the combinational N-bit ALU (ops ADD/AND/OR, zero flag).
//   Accepts commands over valid/ready and sequences one or two ALU passes per command.
//   Builds SUB/CMP from two ADD passes and keeps an accumulator.
//   Returns result, zero and error over a valid/ready response channel.
//   Sits between the control path and the ALU instance; the ALU itself sits beside this block.
// PARAMETERS
//   N   8   datapath width (operands, ALU result, accumulator)
// PORTS
//   clk         in   1    single clock, rising edge
//   rst_n       in   1    asynchronous, active-low reset
//   cmd_valid   in   1    command present
//   cmd_ready   out  1    block can accept a command (high only in IDLE)
//   cmd_op      in   3    0 ADD, 1 AND, 2 OR, 3 SUB, 4 CMP, 5 ACC, 6 CLR, 7 reserved
//   cmd_a       in   N    operand A
//   cmd_b       in   N    operand B
//   alu_op      out  3    to ALU opcode: 0 ADD, 1 AND, 2 OR, 3 NOP (ALU returns 0)
//   alu_a       out  N    to ALU operand 1
//   alu_b       out  N    to ALU operand 2
//   alu_result  in   N    from ALU (combinational)
//   alu_zero    in   1    from ALU (alu_result == 0)
//   rsp_valid   out  1    response held until accepted
//   rsp_ready   in   1    consumer accepts response
//   rsp_result  out  N    final result
//   rsp_zero    out  1    zero flag of the final ALU pass
//   rsp_err     out  1    reserved opcode received
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, all registers 0, rsp_valid=0.
//     rsp_result/rsp_zero/rsp_err=0; alu_op=NOP, alu_a=alu_b=0.
//     Reset mid-command aborts it; acc cleared; no response emitted.
//   - FSM: IDLE -> EXEC1 -> (EXEC2) -> RESP -> IDLE.
//   - IDLE: cmd_ready=1; on cmd_valid&&cmd_ready capture op/a/b.
//     op 7 -> RESP with err=1, result=0, zero=0.
//     All other ops -> EXEC1.
//   - EXEC1: ALU inputs per op; result and zero registered at the end of the cycle.
//     ADD/AND/OR: alu_a=a, alu_b=b, alu_op=op -> RESP.
//     SUB/CMP: alu_a=~b, alu_b=1, ADD; result -> tmp -> EXEC2.
//     ACC: alu_a=acc, alu_b=a, ADD; acc<=result -> RESP.
//     CLR: alu_op=NOP; acc<=result (0); zero=1 -> RESP.
//   - EXEC2: alu_a=a, alu_b=tmp, ADD -> RESP.
//     SUB result = a-b mod 2^N; CMP returns the same result (zero=1 iff a==b).
//   - RESP: rsp_valid=1; outputs stable until rsp_ready; on handshake -> IDLE.
//     rsp_valid deasserts in the same cycle the block returns to IDLE.
//   - Outside EXEC1/EXEC2: alu_op=NOP, alu_a=alu_b=0.
//   - Arithmetic: all sums truncated to N bits; no carry or overflow reported.
//     b=0 in SUB: ~0+1 wraps to 0 and the result is a.
//   - Latency (accept to rsp_valid): ADD/AND/OR/ACC/CLR 2 cycles, SUB/CMP 3, reserved 1.
//   - Throughput: one command in flight; cmd_ready=0 from accept until RESP handshake completes.
//   - rsp_ready held high in RESP: handshake completes on the first RESP cycle.
//     Next command can be accepted one cycle later (IDLE).
// STRUCTURE
//   - alu_pkg (shared with the ALU): ALU_ADD/ALU_AND/ALU_OR/ALU_NOP localparams.
//     Also cmd_op_e enum (CMD_ADD..CMD_RSVD) and state_e (IDLE, EXEC1, EXEC2, RESP).
//   - No sub-module: one FSM plus operand/tmp/acc/response registers.
//     Bench top instantiates this block and the ALU side by side.
// TESTING
//   1. Reset, then ADD a=8'h7F, b=8'h01 -> rsp_valid 2 cycles after accept.
//      result=8'h80, zero=0, err=0.
//   2. SUB a=8'h05, b=8'h07 -> 3-cycle latency, result=8'hFE, zero=0.
//      SUB a=8'h10, b=8'h00 -> result=8'h10.
//   3. CMP a=8'h3C, b=8'h3C -> zero=1, result=8'h00.
//      AND a=8'hF0, b=8'h0F -> result=0, zero=1.
//   4. CLR; ACC a=8'hF0; ACC a=8'h20 -> results 8'hF0 then 8'h10 (wrap).
//      Then CLR -> result=0, zero=1.
//   5. rsp_ready low 5 cycles in RESP -> outputs stable and cmd_ready=0 throughout.
//      Raise rsp_ready -> IDLE next cycle. Op 7 -> err=1 after 1 cycle.
//   6. Assert rst_n=0 during EXEC2 of a SUB -> immediately IDLE, rsp_valid=0.
//      acc=0; next ACC a=8'h01 returns 8'h01.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: ALU opcodes,
// command opcodes, sequencer states and the command-to-ALU opcode mapping.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_NOP = 3'd3;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_AND  = 3'd1,
        CMD_OR   = 3'd2,
        CMD_SUB  = 3'd3,
        CMD_CMP  = 3'd4,
        CMD_ACC  = 3'd5,
        CMD_CLR  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Single-pass commands map straight onto an ALU opcode; everything else
    // is sequenced explicitly by the FSM.
    function automatic logic [2:0] alu_code(cmd_op_e op);
        case (op)
            CMD_ADD: return ALU_ADD;
            CMD_AND: return ALU_AND;
            CMD_OR:  return ALU_OR;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels of the ALU command sequencer.
// master = control path issuing commands, slave = the sequencer.
interface alu_cmd_sequencer_if #(
    parameter int N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Multicycle command front-end for a combinational ADD/AND/OR ALU: one or two
// ALU passes per command, SUB/CMP built from two ADDs, plus an accumulator.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC1 | first ALU pass (all non-reserved commands)
// EXEC2 | second ALU pass: a + (~b + 1) for SUB/CMP
// RESP  | response held on rsp_* until rsp_ready
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus,
    output logic [2:0]          alu_op,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    input  logic [N-1:0]        alu_result,
    input  logic                alu_zero
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state;
    cmd_op_e      op_q;
    logic [N-1:0] a_q;
    logic [N-1:0] acc;

    logic         rsp_valid;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_zero   = rsp_zero;
    assign bus.rsp_err    = rsp_err;

    // ALU drive registers are loaded one cycle ahead, so they already carry
    // the operands of the pass executed in the state being entered. During
    // EXEC2 alu_b holds the two's complement of b (the tmp value).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= CMD_ADD;
            a_q        <= '0;
            acc        <= '0;
            alu_op     <= ALU_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q <= cmd_op_e'(bus.cmd_op);
                        a_q  <= bus.cmd_a;
                        case (cmd_op_e'(bus.cmd_op))
                            CMD_ADD, CMD_AND, CMD_OR: begin
                                alu_op <= alu_code(cmd_op_e'(bus.cmd_op));
                                alu_a  <= bus.cmd_a;
                                alu_b  <= bus.cmd_b;
                                state  <= EXEC1;
                            end
                            CMD_SUB, CMD_CMP: begin
                                alu_op <= ALU_ADD;
                                alu_a  <= ~bus.cmd_b;
                                alu_b  <= ONE;
                                state  <= EXEC1;
                            end
                            CMD_ACC: begin
                                alu_op <= ALU_ADD;
                                alu_a  <= acc;
                                alu_b  <= bus.cmd_a;
                                state  <= EXEC1;
                            end
                            CMD_CLR: begin
                                alu_op <= ALU_NOP;
                                alu_a  <= '0;
                                alu_b  <= '0;
                                state  <= EXEC1;
                            end
                            default: begin
                                rsp_valid  <= 1'b1;
                                rsp_result <= '0;
                                rsp_zero   <= 1'b0;
                                rsp_err    <= 1'b1;
                                state      <= RESP;
                            end
                        endcase
                    end
                end

                EXEC1: begin
                    case (op_q)
                        CMD_SUB, CMD_CMP: begin
                            alu_op <= ALU_ADD;
                            alu_a  <= a_q;
                            alu_b  <= alu_result;
                            state  <= EXEC2;
                        end
                        default: begin
                            alu_op     <= ALU_NOP;
                            alu_a      <= '0;
                            alu_b      <= '0;
                            rsp_valid  <= 1'b1;
                            rsp_result <= alu_result;
                            rsp_zero   <= (op_q == CMD_CLR) ? 1'b1 : alu_zero;
                            rsp_err    <= 1'b0;
                            if (op_q == CMD_ACC || op_q == CMD_CLR) begin
                                acc <= alu_result;
                            end
                            state      <= RESP;
                        end
                    endcase
                end

                EXEC2: begin
                    alu_op     <= ALU_NOP;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_err    <= 1'b0;
                    state      <= RESP;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: sequencer and a behavioural ALU side by side,
// directed vector table, reset-abort sequence and randomized commands.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_result;
    logic         alu_zero;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] model_acc = '0;

    alu_cmd_sequencer_if #(.N(N)) bus ();

    alu_cmd_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // Combinational ALU beside the sequencer
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a & alu_b;
            3'd2:    alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] result;
        logic         zero;
        logic         err;
        int           lat;
    } exp_t;

    // Reference: command semantics straight from the opcode definitions
    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic [N-1:0] acc);
        exp_t e;
        logic [N-1:0] r;
        r = '0;
        e.err = 1'b0;
        e.lat = 2;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3, 3'd4: begin r = a - b; e.lat = 3; end
            3'd5: r = acc + a;
            3'd6: r = '0;
            default: begin r = '0; e.err = 1'b1; e.lat = 1; end
        endcase
        e.result = r;
        e.zero   = (op == 3'd7) ? 1'b0 : (r == '0);
        return e;
    endfunction

    task automatic run_cmd(input string nm, input logic [2:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b, input exp_t e, input int hold);
        int lat;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.rsp_ready = 1'b0;
        check({nm, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(e.lat));
        if (!bus.rsp_valid) begin
            check({nm, " rsp_valid timeout"}, 32'(bus.rsp_valid), 32'd1);
            return;
        end
        check({nm, " result"}, 32'(bus.rsp_result), 32'(e.result));
        check({nm, " zero"}, 32'(bus.rsp_zero), 32'(e.zero));
        check({nm, " err"}, 32'(bus.rsp_err), 32'(e.err));
        check({nm, " busy alu/ready"}, {26'd0, alu_op, bus.cmd_ready, 2'd0}, {26'd0, ALU_NOP, 1'b0, 2'd0});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s hold%0d", nm, k),
                  {20'd0, bus.rsp_valid, bus.cmd_ready, bus.rsp_result, bus.rsp_zero, bus.rsp_err},
                  {20'd0, 1'b1, 1'b0, e.result, e.zero, e.err});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({nm, " after handshake"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, {30'd0, 1'b0, 1'b1});
        bus.rsp_ready = 1'b0;
        if (op == 3'd5) model_acc = model_acc + a;
        if (op == 3'd6) model_acc = '0;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] result;
        logic         zero;
        logic         err;
        int           lat;
        int           hold;
    } vec_t;

    vec_t vecs[14];

    initial begin
        exp_t e;
        logic [2:0]   rop;
        logic [N-1:0] ra, rb;

        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 2, 0};
        vecs[1]  = '{3'd3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 3, 0};
        vecs[2]  = '{3'd3, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 3, 1};
        vecs[3]  = '{3'd4, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0, 3, 0};
        vecs[4]  = '{3'd1, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[5]  = '{3'd6, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[6]  = '{3'd5, 8'hF0, 8'h00, 8'hF0, 1'b0, 1'b0, 2, 0};
        vecs[7]  = '{3'd5, 8'h20, 8'h00, 8'h10, 1'b0, 1'b0, 2, 0};
        vecs[8]  = '{3'd6, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[9]  = '{3'd2, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 2, 5};
        vecs[10] = '{3'd7, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1, 2};
        vecs[11] = '{3'd5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[12] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[13] = '{3'd4, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 3, 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset rsp", {24'd0, bus.rsp_valid, bus.rsp_result[5:0], bus.rsp_zero},
              {24'd0, 1'b0, 6'd0, 1'b0});
        check("reset rsp_err/result_hi", {29'd0, bus.rsp_err, bus.rsp_result[7:6]}, 32'd0);
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset alu drive", {13'd0, alu_op, alu_a, alu_b}, {13'd0, ALU_NOP, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            e.result = vecs[i].result;
            e.zero   = vecs[i].zero;
            e.err    = vecs[i].err;
            e.lat    = vecs[i].lat;
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e, vecs[i].hold);
        end

        // Reset during the second pass of a SUB aborts it and clears acc
        e = model(3'd5, 8'h55, 8'h00, model_acc);
        run_cmd("acc preload", 3'd5, 8'h55, 8'h00, e, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_a     = 8'h09;
        bus.cmd_b     = 8'h03;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sub exec2 alu drive", {13'd0, alu_op, alu_a, alu_b}, {13'd0, ALU_ADD, 8'h09, 8'hFD});
        rst_n = 1'b0;
        #1;
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort alu drive", {13'd0, alu_op, alu_a, alu_b}, {13'd0, ALU_NOP, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        model_acc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("abort no response", 32'(bus.rsp_valid), 32'd0);
        e = model(3'd5, 8'h01, 8'h00, model_acc);
        run_cmd("acc after reset", 3'd5, 8'h01, 8'h00, e, 0);

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            e = model(rop, ra, rb, model_acc);
            run_cmd($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, e, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
